// File: rtl/ring_decoder_checker.sv
// ring_decoder_checker
// Receive-side companion to a one-hot ring counter. Every valid sample is
// decoded to a binary index and tested for one-hot validity. The block locks
// onto the rotation sequence, flags sequence breaks and counts completed laps.
//
// Optional feature (compile-time macro RING_ERR_STICKY_EN):
//   adds input err_clr and output err_sticky. err_sticky sets on any
//   onehot_err / seq_err pulse and holds until err_clr or reset; a set in the
//   same cycle as err_clr wins.
//
// State table:
//   state  | meaning
//   SEARCH | waiting for any valid one-hot sample to anchor on
//   LOCKED | tracking the rotation; counting misses toward MISS_LIMIT
module ring_decoder_checker #(
    parameter  int WIDTH      = 4,
    parameter  int MISS_LIMIT = 2,
    parameter  int LAPW       = 8,
    localparam int IDXW       = $clog2(WIDTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  din,
    input  logic              din_valid,
`ifdef RING_ERR_STICKY_EN
    input  logic              err_clr,
    output logic              err_sticky,
`endif
    output logic [IDXW-1:0]   idx,
    output logic              idx_valid,
    output logic              onehot_err,
    output logic              seq_err,
    output logic              locked,
    output logic [LAPW-1:0]   lap_count
);

    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(WIDTH - 1);
    localparam logic [3:0]       MISS_LAST = 4'(MISS_LIMIT - 1);
    localparam logic [LAPW-1:0]  LAP_ONE   = {{(LAPW-1){1'b0}}, 1'b1};

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  expected;
    logic [3:0]        miss_cnt;
    // Set when the current idx came from a re-anchor after a sequence break;
    // a wrap out of such a position is not a completed lap.
    logic              after_break;

    logic              is_onehot;
    logic [IDXW-1:0]   din_idx;
    logic [WIDTH-1:0]  din_rot;
    logic              in_seq;

    // Decode the incoming sample: validity, bit position and its successor.
    always_comb begin
        is_onehot = (din != '0) && ((din & (din - ONE)) == '0);
        din_idx   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (din[i]) begin
                din_idx = IDXW'(i);
            end
        end
        din_rot = {din[WIDTH-2:0], din[WIDTH-1]};
        in_seq  = is_onehot && (din == expected);
    end

    // Lock FSM with registered index, pulses, miss counter and lap counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SEARCH;
            idx         <= '0;
            idx_valid   <= 1'b0;
            onehot_err  <= 1'b0;
            seq_err     <= 1'b0;
            locked      <= 1'b0;
            lap_count   <= '0;
            miss_cnt    <= '0;
            expected    <= '0;
            after_break <= 1'b0;
        end else begin
            idx_valid  <= 1'b0;
            onehot_err <= 1'b0;
            seq_err    <= 1'b0;
            if (din_valid) begin
                case (state)
                    SEARCH: begin
                        if (is_onehot) begin
                            idx         <= din_idx;
                            idx_valid   <= 1'b1;
                            expected    <= din_rot;
                            miss_cnt    <= '0;
                            after_break <= 1'b0;
                            state       <= LOCKED;
                            locked      <= 1'b1;
                        end else begin
                            onehot_err <= 1'b1;
                        end
                    end
                    LOCKED: begin
                        if (in_seq) begin
                            idx         <= din_idx;
                            idx_valid   <= 1'b1;
                            expected    <= din_rot;
                            miss_cnt    <= '0;
                            after_break <= 1'b0;
                            if (!after_break && (din_idx == '0) && (idx == LAST_IDX)) begin
                                lap_count <= lap_count + LAP_ONE;
                            end
                        end else begin
                            if (is_onehot) begin
                                // Re-anchor on the new position but count it as a miss.
                                seq_err     <= 1'b1;
                                idx         <= din_idx;
                                idx_valid   <= 1'b1;
                                expected    <= din_rot;
                                after_break <= 1'b1;
                            end else begin
                                onehot_err <= 1'b1;
                            end
                            if (miss_cnt == MISS_LAST) begin
                                state    <= SEARCH;
                                locked   <= 1'b0;
                                miss_cnt <= '0;
                            end else begin
                                miss_cnt <= miss_cnt + 4'd1;
                            end
                        end
                    end
                    default: begin
                        state  <= SEARCH;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifdef RING_ERR_STICKY_EN
    logic err_now;

    // An error pulse is being registered this cycle.
    always_comb begin
        err_now = din_valid && (!is_onehot || ((state == LOCKED) && !in_seq));
    end

    // Sticky error flag; a new error outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_sticky <= 1'b0;
        end else if (err_now) begin
            err_sticky <= 1'b1;
        end else if (err_clr) begin
            err_sticky <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_ring_decoder_checker.sv
// Self-checking bench for ring_decoder_checker (WIDTH=4, MISS_LIMIT=2, LAPW=8).
// Directed sequences followed by randomized traffic, all checked against an
// integer-level reference model.
module tb_ring_decoder_checker;

    localparam int W    = 4;
    localparam int MISS = 2;
    localparam int LAPS = 256;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] din;
    logic         din_valid;
    logic [1:0]   idx;
    logic         idx_valid, onehot_err, seq_err, locked;
    logic [7:0]   lap_count;
`ifdef RING_ERR_STICKY_EN
    logic         err_clr;
    logic         err_sticky;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // reference model state
    bit m_locked, m_iv, m_oe, m_se, m_break, m_sticky;
    int m_idx, m_exp, m_miss, m_lap;

    ring_decoder_checker #(.WIDTH(W), .MISS_LIMIT(MISS), .LAPW(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
`ifdef RING_ERR_STICKY_EN
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
`endif
        .idx        (idx),
        .idx_valid  (idx_valid),
        .onehot_err (onehot_err),
        .seq_err    (seq_err),
        .locked     (locked),
        .lap_count  (lap_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_step(input logic [W-1:0] d, input bit v, input bit r, input bit c);
        bit oh;
        int pos;
        m_iv = 0; m_oe = 0; m_se = 0;
        if (r) begin
            m_locked = 0; m_idx = 0; m_exp = 0; m_miss = 0; m_lap = 0;
            m_break = 0; m_sticky = 0;
            return;
        end
        if (v) begin
            oh  = ($countones(d) == 1);
            pos = 0;
            for (int i = 0; i < W; i++) if (d[i]) pos = i;
            if (!m_locked) begin
                if (oh) begin
                    m_idx = pos; m_iv = 1; m_exp = (pos + 1) % W;
                    m_miss = 0; m_locked = 1; m_break = 0;
                end else begin
                    m_oe = 1;
                end
            end else if (oh && pos == m_exp) begin
                if (pos == 0 && m_idx == W - 1 && !m_break) m_lap = (m_lap + 1) % LAPS;
                m_idx = pos; m_iv = 1; m_exp = (pos + 1) % W; m_miss = 0; m_break = 0;
            end else begin
                if (oh) begin
                    m_se = 1; m_iv = 1; m_idx = pos; m_exp = (pos + 1) % W; m_break = 1;
                end else begin
                    m_oe = 1;
                end
                m_miss++;
                if (m_miss >= MISS) begin
                    m_locked = 0; m_miss = 0;
                end
            end
        end
        if (m_oe || m_se) m_sticky = 1;
        else if (c)       m_sticky = 0;
    endfunction

    task automatic check_all();
        chk("idx",        int'(idx),        m_idx);
        chk("idx_valid",  int'(idx_valid),  int'(m_iv));
        chk("onehot_err", int'(onehot_err), int'(m_oe));
        chk("seq_err",    int'(seq_err),    int'(m_se));
        chk("locked",     int'(locked),     int'(m_locked));
        chk("lap_count",  int'(lap_count),  m_lap);
`ifdef RING_ERR_STICKY_EN
        chk("err_sticky", int'(err_sticky), int'(m_sticky));
`endif
    endtask

    task automatic step(input logic [W-1:0] d, input bit v, input bit r, input bit c);
        @(negedge clk);
        din = d; din_valid = v; reset = r;
`ifdef RING_ERR_STICKY_EN
        err_clr = c;
`endif
        @(posedge clk);
        #1;
        model_step(d, v, r, c);
        check_all();
    endtask

    task automatic lap_seq(input int n);
        for (int i = 0; i < n; i++) begin
            step(4'b0001, 1, 0, 0); step(4'b0010, 1, 0, 0);
            step(4'b0100, 1, 0, 0); step(4'b1000, 1, 0, 0);
        end
    endtask

    initial begin
        logic [W-1:0] d;
        int sel;
        din = '0; din_valid = 0; reset = 1;
`ifdef RING_ERR_STICKY_EN
        err_clr = 0;
`endif
        step(4'b0000, 0, 1, 0);
        step(4'b0000, 0, 1, 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_lap", int'(lap_count), 0);

        // full lap from reset
        lap_seq(1);
        step(4'b0001, 1, 0, 0);
        chk("tp1_lap", int'(lap_count), 1);
        chk("tp1_idx", int'(idx), 0);

        // sequence break then in-sequence wrap that must not count
        step(4'b0010, 1, 0, 0);
        step(4'b1000, 1, 0, 0);
        chk("tp2_seq_err", int'(seq_err), 1);
        chk("tp2_idx", int'(idx), 3);
        step(4'b0001, 1, 0, 0);
        chk("tp2_lap", int'(lap_count), 1);
        chk("tp2_noerr", int'(seq_err), 0);

        // two bad samples drop the lock, then relock
        step(4'b0000, 1, 0, 0);
        step(4'b0110, 1, 0, 0);
        chk("tp3_locked", int'(locked), 0);
        chk("tp3_idx", int'(idx), 0);
        step(4'b0100, 1, 0, 0);
        chk("tp3_relock", int'(idx), 2);

        // idle gap holds everything
        step(4'b1000, 1, 0, 0); step(4'b0001, 1, 0, 0); step(4'b0010, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(4'($urandom), 0, 0, 0);
        step(4'b0100, 1, 0, 0);
        chk("tp4_seq_err", int'(seq_err), 0);

        // reset while locked with laps counted; din_valid ignored
        step(4'b0000, 0, 1, 0);
        lap_seq(6);
        chk("tp5_lap_pre", int'(lap_count), 5);
        step(4'b0001, 1, 1, 0);
        chk("tp5_locked", int'(locked), 0);
        chk("tp5_lap", int'(lap_count), 0);

        // lap counter wrap
        lap_seq(258);
        chk("wrap_lap", int'(lap_count), 1);

`ifdef RING_ERR_STICKY_EN
        step(4'b0011, 1, 0, 0);
        step(4'b0000, 0, 0, 0);
        chk("stk_hold", int'(err_sticky), 1);
        step(4'b0000, 0, 0, 1);
        chk("stk_clr", int'(err_sticky), 0);
        step(4'b0001, 1, 0, 0);
        step(4'b1000, 1, 0, 1);
        chk("stk_prio", int'(err_sticky), 1);
`endif

        // randomized traffic
        step(4'b0000, 0, 1, 0);
        for (int n = 0; n < 3000; n++) begin
            sel = int'($urandom_range(0, 99));
            if (sel < 55)      d = 4'(1 << m_exp);
            else if (sel < 75) d = 4'(1 << $urandom_range(0, W - 1));
            else               d = 4'($urandom);
            step(d, ($urandom_range(0, 3) != 0), ($urandom_range(0, 199) == 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
